// File: rtl/ring_pkg.sv
// Shared definitions for the ring NoC injection path: packet layout,
// traffic patterns, controller states and the destination helper.
package ring_pkg;

  localparam int PKT_W     = 49;
  localparam int VALID_BIT = 48;
  localparam int TS_LSB    = 32;
  localparam int TS_MSB    = 47;
  localparam int SRC_LSB   = 16;
  localparam int SRC_MSB   = 31;
  localparam int DST_LSB   = 0;
  localparam int DST_MSB   = 15;

  typedef struct packed {
    logic        valid;
    logic [15:0] ts;
    logic [15:0] src;
    logic [15:0] dst;
  } pkt_t;

  typedef enum logic {
    TP_BITCOMP   = 1'b0,
    TP_NEIGHBOUR = 1'b1
  } traffic_pattern_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } inj_state_e;

  // Destination for a node under the given pattern; num_nodes is a power of 2.
  function automatic logic [15:0] dst_calc(traffic_pattern_e tp,
                                           int unsigned node_id,
                                           int unsigned num_nodes);
    logic [31:0] mask;
    logic [31:0] res;
    mask = num_nodes - 1;
    if (tp == TP_NEIGHBOUR) res = (node_id + 1) & mask;
    else                    res = ~node_id & mask;
    return res[15:0];
  endfunction

endpackage

// File: rtl/ring_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers. A push while full is accepted
// when a pop happens in the same cycle, so occupancy stays full.
module ring_sync_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rptr_q[AW-1:0]];

  // Pointer update; both pointers return to zero on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage write.
  // NOTE: the array has no reset; emptiness comes from the pointers, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ring_inject_ctrl.sv
// Per-node injection controller: paces packet generation, buffers packets in
// a source queue and offers them to the ring router over valid/ready.
module ring_inject_ctrl #(
  parameter int NUM_NODES            = 4,
  parameter int NODE_ID              = 0,
  parameter int PACKET_SIZE          = 49,
  parameter int INJECT_CYCLE         = 2,
  parameter int NUM_PACKETS_PER_NODE = 20,
  parameter int TRAFFIC_PATTERN      = 0,
  parameter int QUEUE_DEPTH          = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic [PACKET_SIZE-1:0] pkt_out_data,
  output logic                   pkt_out_valid,
  input  logic                   pkt_out_ready,
  output logic [15:0]            gen_count,
  output logic [15:0]            sent_count,
  output logic                   busy,
  output logic                   done
);

  import ring_pkg::*;

  if (PACKET_SIZE != PKT_W) begin : g_bad_packet_size
    $error("ring_inject_ctrl: PACKET_SIZE must be %0d", PKT_W);
  end
  if (INJECT_CYCLE < 1 || NUM_PACKETS_PER_NODE < 1) begin : g_bad_rate
    $error("ring_inject_ctrl: INJECT_CYCLE and NUM_PACKETS_PER_NODE must be >= 1");
  end
  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ring_inject_ctrl: QUEUE_DEPTH must be a power of 2 and >= 2");
  end

  localparam int               ICW    = (INJECT_CYCLE > 1) ? $clog2(INJECT_CYCLE) : 1;
  localparam logic [ICW-1:0]   RELOAD = ICW'(INJECT_CYCLE - 1);
  localparam logic [15:0]      N_PKTS = 16'(NUM_PACKETS_PER_NODE);
  localparam traffic_pattern_e TP     = (TRAFFIC_PATTERN == 1) ? TP_NEIGHBOUR : TP_BITCOMP;
  localparam logic [15:0]      SRC    = 16'(NODE_ID);
  localparam logic [15:0]      DST    = dst_calc(TP, NODE_ID, NUM_NODES);

  inj_state_e       state_q, state_d;
  logic [ICW-1:0]   icnt_q;
  logic [15:0]      ts_q;
  logic             gen;
  logic             pop;
  logic             space;
  logic             q_full;
  logic             q_empty;
  pkt_t             new_pkt;
  logic [PKT_W-1:0] head;

  assign new_pkt       = '{valid: 1'b1, ts: ts_q, src: SRC, dst: DST};
  assign pkt_out_valid = !q_empty;
  assign pkt_out_data  = pkt_out_valid ? head : '0;
  assign pop           = pkt_out_valid && pkt_out_ready;
  assign space         = !q_full || pop;
  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);

  ring_sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (gen),
    .push_data (new_pkt),
    .pop       (pop),
    .head_data (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Next state and the generate event.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    gen     = 1'b0;
    unique case (state_q)
      IDLE:  if (en) state_d = RUN;
      RUN: begin
        gen = en && (icnt_q == '0) && space;
        if (gen && (gen_count + 16'd1 == N_PKTS)) state_d = DRAIN;
      end
      DRAIN: if (pop && (sent_count + 16'd1 == N_PKTS)) state_d = DONE;
      DONE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State register, pacing counter, timestamp and packet counters.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      icnt_q     <= '0;
      ts_q       <= '0;
      gen_count  <= '0;
      sent_count <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_q + 16'd1;
      if (state_q == IDLE && en)                          icnt_q <= '0;
      else if (gen)                                       icnt_q <= RELOAD;
      else if (state_q == RUN && en && icnt_q != '0)      icnt_q <= icnt_q - ICW'(1);
      if (gen) gen_count  <= gen_count + 16'd1;
      if (pop) sent_count <= sent_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ring_inject_ctrl.sv
// Bench for ring_inject_ctrl: a main instance checked every cycle against a
// queue-based reference model, plus three instances with other parameters.
module tb_ring_inject_ctrl;

  localparam int M_NODE  = 1;
  localparam int M_NODES = 4;
  localparam int M_N     = 20;
  localparam int M_DEPTH = 4;
  localparam int M_GAP   = 2;
  localparam int M_DST   = (~M_NODE) & (M_NODES - 1);

  logic        clk = 1'b0;
  logic        rst_n, en, pkt_out_ready, en_x, ready_x;
  logic [48:0] pkt_out_data, nb_data, bc_data, f_data;
  logic        pkt_out_valid, nb_valid, bc_valid, f_valid;
  logic [15:0] gen_count, sent_count, nb_gen, nb_sent, bc_gen, bc_sent, f_gen, f_sent;
  logic        busy, done, nb_busy, nb_done, bc_busy, bc_done, f_busy, f_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ring_inject_ctrl #(.NODE_ID(M_NODE)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pkt_out_data(pkt_out_data),
    .pkt_out_valid(pkt_out_valid), .pkt_out_ready(pkt_out_ready),
    .gen_count(gen_count), .sent_count(sent_count), .busy(busy), .done(done));

  ring_inject_ctrl #(.NODE_ID(3), .TRAFFIC_PATTERN(1)) u_nb (
    .clk(clk), .rst_n(rst_n), .en(en_x), .pkt_out_data(nb_data),
    .pkt_out_valid(nb_valid), .pkt_out_ready(ready_x),
    .gen_count(nb_gen), .sent_count(nb_sent), .busy(nb_busy), .done(nb_done));

  ring_inject_ctrl #(.NODE_ID(0), .TRAFFIC_PATTERN(0)) u_bc (
    .clk(clk), .rst_n(rst_n), .en(en_x), .pkt_out_data(bc_data),
    .pkt_out_valid(bc_valid), .pkt_out_ready(ready_x),
    .gen_count(bc_gen), .sent_count(bc_sent), .busy(bc_busy), .done(bc_done));

  ring_inject_ctrl #(.INJECT_CYCLE(1), .QUEUE_DEPTH(2)) u_fast (
    .clk(clk), .rst_n(rst_n), .en(en_x), .pkt_out_data(f_data),
    .pkt_out_valid(f_valid), .pkt_out_ready(ready_x),
    .gen_count(f_gen), .sent_count(f_sent), .busy(f_busy), .done(f_done));

  // Reference model of the main instance, built from counts and a packet queue.
  logic [48:0] m_q[$];
  logic [48:0] got_q[$];
  logic [15:0] m_ts;
  int          m_gap, m_gen, m_sent;
  bit          m_started;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit pop, run, gen_ev;
    if (!rst_n) begin
      m_q.delete();
      m_gap = 0; m_gen = 0; m_sent = 0; m_ts = '0; m_started = 0;
      return;
    end
    pop    = (m_q.size() > 0) && pkt_out_ready;
    run    = m_started && (m_gen < M_N);
    gen_ev = run && en && (m_gap == 0) && ((m_q.size() < M_DEPTH) || pop);
    if (pop) begin
      void'(m_q.pop_front());
      m_sent++;
    end
    if (gen_ev) begin
      m_q.push_back({1'b1, m_ts, 16'(M_NODE), 16'(M_DST)});
      m_gen++;
      m_gap = M_GAP - 1;
    end else if (run && en && m_gap > 0) begin
      m_gap--;
    end
    if (!m_started && en) begin
      m_started = 1;
      m_gap     = 0;
    end
    m_ts = m_ts + 16'd1;
  endtask

  task automatic compare_model();
    logic [48:0] exp_data;
    exp_data = '0;
    if (m_q.size() > 0) exp_data = m_q[0];
    check("valid", pkt_out_valid, m_q.size() > 0);
    check("data", pkt_out_data, exp_data);
    check("gen_count", gen_count, m_gen);
    check("sent_count", sent_count, m_sent);
    check("busy", busy, m_started && (m_sent < M_N));
    check("done", done, m_started && (m_sent == M_N));
  endtask

  // One clock: log main transfers, advance the model, compare after the edge.
  task automatic tick();
    if (pkt_out_valid && pkt_out_ready) got_q.push_back(pkt_out_data);
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; en_x = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    got_q.delete();
  endtask

  initial begin
    logic [48:0] first;
    int          bad;
    rst_n = 1'b0; en = 1'b0; en_x = 1'b0; pkt_out_ready = 1'b0; ready_x = 1'b0;

    // Reset state.
    do_reset();
    check("rst_valid", pkt_out_valid, 0);
    check("rst_data", pkt_out_data, 0);
    check("rst_gen", gen_count, 0);
    check("rst_busy", busy, 0);

    // Test 1: free-flowing run of 20 packets.
    en = 1'b1; pkt_out_ready = 1'b1;
    for (int i = 0; i < 300 && !done; i++) tick();
    check("t1_done", done, 1);
    check("t1_gen", gen_count, M_N);
    check("t1_sent", sent_count, M_N);
    check("t1_count", got_q.size(), M_N);
    bad = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i][31:16] != 16'(M_NODE) || got_q[i][15:0] != 16'(M_DST) || !got_q[i][48]) bad++;
      if (i > 0 && (got_q[i][47:32] - got_q[i-1][47:32]) != 16'd2) bad++;
    end
    check("t1_fields_spacing", bad, 0);

    // Test 2: backpressure from the start, then release.
    do_reset();
    en = 1'b1; pkt_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    first = pkt_out_data;
    for (int i = 0; i < 20; i++) tick();
    check("t2_gen_stall", gen_count, M_DEPTH);
    check("t2_valid", pkt_out_valid, 1);
    check("t2_head_stable", pkt_out_data, first);
    pkt_out_ready = 1'b1;
    for (int i = 0; i < 300 && !done; i++) tick();
    check("t2_count", got_q.size(), M_N);
    check("t2_first", got_q[0], first);
    bad = 0;
    for (int i = 1; i < got_q.size(); i++)
      if (got_q[i][47:32] <= got_q[i-1][47:32]) bad++;
    check("t2_ts_increasing", bad, 0);

    // Test 4: pause generation after the fifth packet.
    do_reset();
    en = 1'b1; pkt_out_ready = 1'b1;
    for (int i = 0; i < 100 && gen_count != 16'd5; i++) tick();
    check("t4_reach5", gen_count, 5);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_gen_hold", gen_count, 5);
      check("t4_busy", busy, 1);
    end
    check("t4_drained", pkt_out_valid, 0);
    en = 1'b1;
    tick();
    check("t4_resume_wait", gen_count, 5);
    tick();
    check("t4_resume_gen", gen_count, 6);

    // Test 5: reset mid-run with the queue non-empty.
    do_reset();
    en = 1'b1; pkt_out_ready = 1'b1;
    for (int i = 0; i < 100 && gen_count != 16'd7; i++) tick();
    check("t5_reach7", gen_count, 7);
    check("t5_nonempty", pkt_out_valid, 1);
    rst_n = 1'b0;
    tick();
    check("t5_valid", pkt_out_valid, 0);
    check("t5_data", pkt_out_data, 0);
    check("t5_gen", gen_count, 0);
    check("t5_sent", sent_count, 0);
    check("t5_idle", {busy, done}, 2'b00);
    rst_n = 1'b1;
    tick();
    check("t5_restart_busy", busy, 1);
    tick();
    check("t5_restart_gen", gen_count, 1);

    // Randomised en/ready run against the model.
    do_reset();
    for (int i = 0; i < 800 && !done; i++) begin
      en            = ($urandom_range(0, 9) != 0);
      pkt_out_ready = $urandom_range(0, 1) == 1;
      tick();
    end
    check("rand_done", done, 1);
    check("rand_count", got_q.size(), M_N);

    // Tests 3 and 6: other parameter sets, main instance held idle.
    do_reset();
    pkt_out_ready = 1'b0; ready_x = 1'b1; en_x = 1'b1;
    tick();
    check("t6_run_entry", f_busy, 1);
    for (int j = 2; j <= 50; j++) begin
      if (nb_valid) begin
        check("t3_nb_src", nb_data[31:16], 3);
        check("t3_nb_dst", nb_data[15:0], 0);
      end
      if (bc_valid) begin
        check("t3_bc_src", bc_data[31:16], 0);
        check("t3_bc_dst", bc_data[15:0], 3);
      end
      tick();
      if (j >= 2 && j <= 21) check("t6_valid", f_valid, 1);
      if (j >= 3 && j <= 22) check("t6_sent", f_sent, j - 2);
      if (j == 21) check("t6_not_done", f_done, 0);
      if (j == 22) check("t6_done", f_done, 1);
    end
    check("t3_nb_done", nb_done, 1);
    check("t3_nb_gen", nb_gen, M_N);
    check("t3_bc_done", bc_done, 1);
    check("t3_bc_sent", bc_sent, M_N);
    check("t6_gen", f_gen, M_N);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
